// File: rtl/i2c_slave_regfile_if.sv
// i2c_slave_regfile_if: register-file commit bus of the I2C target.
// master = the target that commits bytes, slave = whoever consumes them.
`timescale 1ns/1ps
interface i2c_slave_regfile_if #(
    parameter int AW = 2
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_valid,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a small register file and an
// auto-incrementing pointer; register 0 mirrors onto the board LEDs.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR = 7'h55,
    parameter int         NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SCL,
    inout  wire                 SDA,
    output logic [7:0]          LED,
    output logic                busy,
    i2c_slave_regfile_if.master wr
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WR_ACK,
        RDATA,
        RACK,
        IGNORE
    } state_t;

    state_t        state;
    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic          scl_rise, scl_fall;
    logic          sda_rise, sda_fall;
    logic          start_c, stop_c;
    logic [7:0]    shift;
    logic [7:0]    rx_byte;
    logic [3:0]    cnt;
    logic          rw;
    logic [AW-1:0] ptr;
    logic          sda_oe;
    logic [7:0]    regs [NUM_REGS];

    // Open-drain: only ever pull low or let the bus pull-up win
    assign SDA = sda_oe ? 1'b0 : 1'bz;
    assign LED = regs[0];

    // Bring SCL/SDA into the clk domain, keeping one older sample for edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Edge pulses, bus conditions and the byte as it would look after a shift
    always_comb begin
        scl_rise = scl_s2 & ~scl_d;
        scl_fall = ~scl_s2 & scl_d;
        sda_rise = sda_s2 & ~sda_d;
        sda_fall = ~sda_s2 & sda_d;
        start_c  = sda_fall & scl_s2;
        stop_c   = sda_rise & scl_s2;
        rx_byte  = {shift[6:0], sda_s2};
    end

    // Protocol FSM, register file, commit strobe and SDA drive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            shift       <= '0;
            cnt         <= '0;
            rw          <= 1'b0;
            ptr         <= '0;
            wr.wr_valid <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr.wr_valid <= 1'b0;
            if (start_c) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                if (rx_byte[7:1] == SLV_ADDR) begin
                                    rw   <= rx_byte[0];
                                    busy <= 1'b1;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IGNORE;
                                end
                            end
                        end else if (scl_fall && cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!rw) begin
                                sda_oe <= 1'b0;
                                cnt    <= '0;
                                state  <= PTR;
                            end else begin
                                // bit 7 goes out now, so one bit is done
                                shift  <= {regs[ptr][6:0], 1'b0};
                                sda_oe <= ~regs[ptr][7];
                                cnt    <= 4'd1;
                                state  <= RDATA;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                ptr <= rx_byte[AW-1:0];
                            end
                        end else if (scl_fall && cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= PTR_ACK;
                        end
                    end
                    PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                regs[ptr]   <= rx_byte;
                                wr.wr_valid <= 1'b1;
                                wr.wr_addr  <= ptr;
                                wr.wr_data  <= rx_byte;
                                ptr         <= ptr + 1'b1;
                            end
                        end else if (scl_fall && cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                ptr    <= ptr + 1'b1;
                                cnt    <= '0;
                                state  <= RACK;
                            end else begin
                                sda_oe <= ~shift[7];
                                shift  <= {shift[6:0], 1'b0};
                                cnt    <= cnt + 4'd1;
                            end
                        end
                    end
                    RACK: begin
                        // entered on a fall, so the next fall follows the
                        // sampled ACK; a NACK leaves straight away
                        if (scl_rise && sda_s2) begin
                            sda_oe <= 1'b0;
                            state  <= IGNORE;
                        end else if (scl_fall) begin
                            shift  <= {regs[ptr][6:0], 1'b0};
                            sda_oe <= ~regs[ptr][7];
                            cnt    <= 4'd1;
                            state  <= RDATA;
                        end
                    end
                    IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master against a register-file model;
// expected ACKs, read bytes and commits are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int Q = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl   = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    logic [7:0] led;
    logic       busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_regfile_if #(.AW(2)) wr_if ();

    i2c_slave_regfile #(
        .SLV_ADDR(7'h55),
        .NUM_REGS(4)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .SCL  (scl),
        .SDA  (sda),
        .LED  (led),
        .busy (busy),
        .wr   (wr_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } exp_t;

    int         n_cmp = 0;
    int         n_err = 0;
    exp_t       exp_q [$];
    logic [7:0] obs_q [$];
    logic [9:0] wr_q [$];
    logic [7:0] mreg [4];
    int         mptr = 0;
    logic [7:0] dbuf [4];
    logic       no_drive = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic exp_push(input string nm, input logic [7:0] v);
        exp_t x;
        x.nm = nm;
        x.v  = v;
        exp_q.push_back(x);
    endtask

    task automatic bit_wr(input logic b);
        #Q m_low = ~b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic bit_rd(output logic b);
        #Q m_low = 1'b0;
        #Q scl = 1'b1;
        #Q b = (sda === 1'b0) ? 1'b0 : 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic do_start();
        #Q m_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_low = 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic do_stop();
        #Q m_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_low = 1'b0;
        #Q;
    endtask

    // Send a byte, expect the target's ACK (1) or silence (0)
    task automatic send(input string nm, input logic exp_ack,
                        input logic [7:0] d);
        logic a;
        exp_push(nm, {7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) bit_wr(d[i]);
        bit_rd(a);
        obs_q.push_back({7'd0, ~a});
    endtask

    task automatic recv(input logic ack);
        logic [7:0] d;
        logic       b;
        exp_push("rd_data", mreg[mptr]);
        mptr = (mptr + 1) % 4;
        for (int i = 7; i >= 0; i--) begin
            bit_rd(b);
            d[i] = b;
        end
        bit_wr(~ack);
        obs_q.push_back(d);
    endtask

    task automatic wr_txn(input logic [6:0] a, input logic [7:0] p,
                          input int n);
        logic hit;
        hit = (a == 7'h55);
        no_drive = ~hit;
        do_start();
        send("addr_ack", hit, {a, 1'b0});
        chk("busy_addr", busy, hit);
        send("ptr_ack", hit, p);
        if (hit) mptr = p % 4;
        for (int i = 0; i < n; i++) begin
            if (hit) begin
                wr_q.push_back({mptr[1:0], dbuf[i]});
                mreg[mptr] = dbuf[i];
                mptr = (mptr + 1) % 4;
            end
            send("data_ack", hit, dbuf[i]);
        end
        do_stop();
        no_drive = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_stop", busy, 0);
        chk("led", led, mreg[0]);
    endtask

    task automatic rd_txn(input logic [7:0] p, input int n);
        do_start();
        send("addr_ack", 1'b1, 8'hAA);
        send("ptr_ack", 1'b1, p);
        mptr = p % 4;
        do_start();
        send("raddr_ack", 1'b1, 8'hAB);
        chk("busy_read", busy, 1);
        for (int i = 0; i < n; i++) recv(i < n - 1);
        repeat (3) @(negedge clk);
        chk("sda_after_nack", sda, 1);
        do_stop();
        repeat (2) @(negedge clk);
        chk("busy_stop", busy, 0);
    endtask

    // Monitor: commit strobes, observed bus bytes/ACKs, and a silent target
    initial begin
        logic [9:0] e;
        exp_t       x;
        logic [7:0] o;
        forever begin
            @(negedge clk);
            if (rst_n && wr_if.wr_valid) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wr_unexpected: got addr %0d data %0h required no commit",
                             wr_if.wr_addr, wr_if.wr_data);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", wr_if.wr_addr, e[9:8]);
                    chk("wr_data", wr_if.wr_data, e[7:0]);
                end
            end
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bus_unexpected: got %0h required nothing", o);
                end else begin
                    x = exp_q.pop_front();
                    chk(x.nm, o, x.v);
                end
            end
            if (no_drive && !m_low) chk("sda_not_driven", sda, 1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         kind;
        int         n;
        logic [7:0] p;
        logic [6:0] a;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_valid", wr_if.wr_valid, 0);
        chk("rst_sda", sda, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        dbuf[0] = 8'h01;
        wr_txn(7'h55, 8'h00, 1);

        dbuf[0] = 8'h77;
        wr_txn(7'h53, 8'h00, 1);

        dbuf[0] = 8'h11;
        dbuf[1] = 8'h22;
        wr_txn(7'h55, 8'h03, 2);

        dbuf[0] = 8'h5A;
        dbuf[1] = 8'hC3;
        dbuf[2] = 8'h0F;
        wr_txn(7'h55, 8'h01, 3);
        rd_txn(8'h01, 3);

        do_start();
        send("addr_ack", 1'b1, 8'hAA);
        send("ptr_ack", 1'b1, 8'h02);
        mptr = 2;
        bit_wr(1'b1);
        bit_wr(1'b0);
        bit_wr(1'b1);
        do_stop();
        repeat (2) @(negedge clk);
        chk("busy_abort", busy, 0);
        dbuf[0] = 8'h99;
        wr_txn(7'h55, 8'h00, 1);
        rd_txn(8'h02, 1);

        for (int k = 0; k < 12; k++) begin
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 3);
            p = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom_range(0, 255));
            case (kind)
                0: wr_txn(7'h55, p, n);
                1: rd_txn(p, n);
                default: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == 7'h55) a = 7'h2A;
                    wr_txn(a, p, n);
                end
            endcase
        end

        dbuf[0] = 8'h3C;
        wr_txn(7'h55, 8'h01, 1);
        do_start();
        send("addr_ack", 1'b1, 8'hAA);
        send("ptr_ack", 1'b1, 8'h01);
        do_start();
        send("raddr_ack", 1'b1, 8'hAB);
        #Q;
        chk("rd_bit7_low", sda, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("sda_on_reset", sda, 1);
        chk("led_on_reset", led, 0);
        chk("busy_on_reset", busy, 0);
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send("nostart_ack", 1'b0, 8'hAA);
        do_stop();
        repeat (2) @(negedge clk);
        chk("busy_nostart", busy, 0);
        rd_txn(8'h00, 4);

        repeat (5) @(negedge clk);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("bus_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target (responder) for the team's I2C_Master; sits on the shared SCL/SDA bus as the far end of the link.
- Decodes START/STOP, matches a 7-bit address, and drives ACK and read data on SDA.
- Holds a 4 x 8-bit register file with an auto-incrementing pointer; register 0 drives the board LEDs.
- SCL is input only: no clock stretching.

Parameters:
- SLV_ADDR, 7'h55, 7-bit target address. A master byte of 8'hAA is a write to this target; 8'hAB is a read.
- NUM_REGS, 4, number of 8-bit registers. Must be a power of 2; the pointer is log2(NUM_REGS) bits.

Ports:
- clk  input  1  system clock. Must be at least 8x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- SCL  input  1  I2C clock from the master.
- SDA  inout  1  I2C data, open-drain. The block drives only 1'b0 or 'z; the bus has an external pull-up (tri1).
- LED  output  8  mirror of reg[0].
- wr_valid  output  1  one-clk pulse when a data byte is committed to the register file.
- wr_addr  output  2  register index of the committed byte.
- wr_data  output  8  committed byte.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, sda_oe=0 (SDA released immediately).
  - All registers 0; LED=0; pointer=0.
  - wr_valid=0, wr_addr=0, wr_data=0, busy=0, bit counter=0.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer plus a previous-sample register.
  - scl_rise/scl_fall and sda_rise/sda_fall are single-clk pulses derived from the synced values.
- Bus events:
  - START = sda_fall while synced SCL=1.
  - STOP = sda_rise while synced SCL=1.
  - START and STOP take priority over every state. START (including repeated START) goes to ADDR with bit counter=0. STOP goes to IDLE.
  - In both cases sda_oe is cleared in the same clk.
  - The pointer is retained across repeated START.
- Bit timing:
  - SDA is sampled on scl_rise, MSB first.
  - The block changes SDA only on scl_fall, so SDA changes 3 clk after the SCL pin falls.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - After the 8th scl_rise: if shift[7:1]==SLV_ADDR, latch R/W and set busy=1; otherwise go to IGNORE.
    - On the following scl_fall, set sda_oe=1 and go to ADDR_ACK.
  - ADDR_ACK: on scl_fall, release SDA.
    - If R/W=0, go to PTR.
    - If R/W=1, load reg[ptr] into the shift register, drive bit 7 in the same clk, and go to RDATA.
  - PTR: shift 8 bits; pointer = byte[1:0] (upper bits ignored); ACK as in ADDR, then go to WDATA.
  - WDATA: shift 8 bits; on the 8th scl_rise:
    - reg[ptr] <= byte; wr_valid=1 for one clk with wr_addr=ptr and wr_data=byte;
    - ptr <= ptr+1, wrapping 3 -> 0;
    - ACK, then return to WDATA.
  - RDATA: on each scl_fall, drive sda_oe = ~shift[7] and shift left.
    - After the 8th bit's scl_fall, release SDA; ptr <= ptr+1 (wraps); go to RACK.
  - RACK: sample master ACK on scl_rise.
    - ACK (0): on scl_fall, load reg[ptr], drive its bit 7, go to RDATA.
    - NACK (1): go to IGNORE with SDA released.
  - IGNORE: SDA released, no register activity; leave only on START or STOP.
- Boundary conditions:
  - STOP or START mid-byte discards the partial byte; no write occurs.
  - Write and read pointers share one counter.
  - LED updates in the same clk as a reg[0] write.
  - wr_valid never asserts for the address or pointer bytes.
  - A reset mid-transfer must not glitch SDA low; sda_oe is a register cleared asynchronously.
  - An address mismatch never pulls SDA low at any time.

Test Plan:
- Basic write: START, 8'hAA, 8'h00, 8'h01, STOP.
  - SDA low in all three ACK slots.
  - wr_valid pulses once with wr_addr=0, wr_data=8'h01.
  - LED=8'h01; busy falls at STOP.
- Address mismatch: START, 8'hA6, 8'h00, 8'h77, STOP.
  - SDA never driven low; registers unchanged; busy stays 0; wr_valid never pulses.
- Burst write with wrap: START, 8'hAA, ptr 8'h03, 8'h11, 8'h22, STOP.
  - reg[3]=8'h11 and reg[0]=8'h22; LED=8'h22.
  - wr_addr sequence 3 then 0.
- Repeated-START read: preload reg1=8'h5A, reg2=8'hC3, reg3=8'h0F.
  - Send START, 8'hAA, ptr 8'h01, Sr, 8'hAB; master responds ACK, ACK, NACK.
  - Bus returns 8'h5A, 8'hC3, 8'h0F; SDA released after the NACK; STOP returns to IDLE.
- Abort mid-byte: write ptr 8'h02, then STOP after 3 data bits.
  - reg[2] unchanged; no wr_valid; state=IDLE.
  - A following transaction to 8'hAA is ACKed normally.
- Reset mid-read: assert reset while the block drives a 0 data bit.
  - SDA reads 1 (pull-up) within the same clk; LED=0; all registers 0.
  - After release, the block waits for a fresh START.
